// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-side consumer for a dual-clock SRAM FIFO. Issues pops
//               while credit is available, tracks the FIFO read latency with
//               a token pipe, captures returned words into a register skid
//               buffer and presents them on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
    parameter int WIDTH     = 32,
    parameter int RD_LAT    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             idle
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int INF_W = $clog2(RD_LAT + 1) + 1;
    localparam int SUM_W = CNT_W + INF_W;

    logic [CNT_W-1:0]  buf_cnt_q,  buf_cnt_d;
    logic [INF_W-1:0]  infl_cnt_q, infl_cnt_d;
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic [RD_LAT-1:0] tok_q,      tok_d;
    logic [WIDTH-1:0]  mem_q [BUF_DEPTH];

    logic             land;
    logic             pop;
    logic [SUM_W-1:0] outstanding;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit uses registered counts only; no path from out_ready to rinc.
    // rinc is also held low while reset is asserted so the FIFO is never
    // popped during reset.
    always_comb begin
        outstanding = SUM_W'(buf_cnt_q) + SUM_W'(infl_cnt_q);
        rinc        = rst_n & en & ~rempty & (outstanding < SUM_W'(BUF_DEPTH));
    end

    // Token pipe input: a token enters on every pop and exits when the
    // corresponding word is on rdata.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign tok_d = rinc;
        end else begin : g_latn
            assign tok_d = {tok_q[RD_LAT-2:0], rinc};
        end
    endgenerate

    assign land      = tok_q[RD_LAT-1];
    assign out_valid = (buf_cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[head_q];
    assign idle      = (buf_cnt_q == '0) && (infl_cnt_q == '0);

    // Next-state for counters and pointers.
    always_comb begin
        buf_cnt_d  = buf_cnt_q;
        infl_cnt_d = infl_cnt_q + INF_W'(rinc) - INF_W'(land);
        head_d     = head_q;
        tail_d     = tail_q;
        if (land) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        case ({land, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + CNT_W'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - CNT_W'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    // Control state register; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt_q  <= '0;
            infl_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tok_q      <= '0;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            infl_cnt_q <= infl_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tok_q      <= tok_d;
        end
    end

    // Skid buffer storage: landed word written at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (land) begin
            mem_q[tail_q] <= rdata;
        end
    end

endmodule
`default_nettype wire
